// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: data width and the select codes used by the
// forwarding-source and writeback-source selectors.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam int FWD_SRC_REGFILE = 0;
  localparam int FWD_SRC_EXMEM   = 1;
  localparam int FWD_SRC_MEMWB   = 2;
  localparam int FWD_NUM_SRC     = 3;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_MEM  = 1;
  localparam int WB_SRC_PC4  = 2;
  localparam int WB_NUM_SRC  = 3;

endpackage

// File: rtl/skid_reg.sv
// Generic WIDTH-wide two-entry valid/ready register (output register plus one
// skid entry); in_ready comes straight from a flop so out_ready never reaches it.
module skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             accept, deliver;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid_q && out_ready;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Valid bits only; data registers keep their contents.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || deliver) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_data_d = in_data;
      end else if (accept) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = in_data;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/mux_pipe_reg.sv
// N:1 operand selector feeding a registered valid/ready skid stage.
// Define MUX_SEL_CHECK_EN to add the sticky sel_err out-of-range flag.
module mux_pipe_reg
  import mips_pkg::*;
#(
  parameter  int WIDTH      = DATA_W,
  parameter  int NUM_INPUTS = 8,
  localparam int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            select,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready
`ifdef MUX_SEL_CHECK_EN
  ,
  output logic                        sel_err
`endif
);

  logic [WIDTH-1:0] in_arr [NUM_INPUTS];
  logic [WIDTH-1:0] picked;
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;

  genvar gi;
  for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
    assign in_arr[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Indices past NUM_INPUTS (non power-of-2 counts) select a defined zero.
  always_comb begin
    picked  = '0;
    sel_hit = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (select == SEL_W'(k)) begin
        picked  = in_arr[k];
        sel_hit = 1'b1;
      end
    end
    sel_data = sel_hit ? picked : '0;
  end

  skid_reg #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (sel_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

`ifdef MUX_SEL_CHECK_EN
  logic sel_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sel_err_q <= 1'b0;
    else if (in_valid && in_ready && !sel_hit)
      sel_err_q <= 1'b1;
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Bench for mux_pipe_reg: an 8-input instance checked against a queue model,
// plus a 5-input instance for out-of-range selects (MUX_SEL_CHECK_EN aware).
module tb_mux_pipe_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-input instance
  logic [31:0]  words8 [8];
  logic [255:0] in_data8;
  logic [2:0]   select8;
  logic         in_valid8, in_ready8, flush8, out_valid8, out_ready8;
  logic [31:0]  out_data8;
  // 5-input instance
  logic [31:0]  words5 [5];
  logic [159:0] in_data5;
  logic [2:0]   select5;
  logic         in_valid5, in_ready5, flush5, out_valid5, out_ready5;
  logic [31:0]  out_data5;
`ifdef MUX_SEL_CHECK_EN
  logic sel_err8, sel_err5;
`endif

  always_comb begin
    in_data8 = '0;
    for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = words8[k];
  end
  always_comb begin
    in_data5 = '0;
    for (int k = 0; k < 5; k++) in_data5[k*32 +: 32] = words5[k];
  end

  mux_pipe_reg #(.WIDTH(32), .NUM_INPUTS(8)) u_dut8 (
    .clk(clk), .reset(reset), .in_data(in_data8), .select(select8),
    .in_valid(in_valid8), .in_ready(in_ready8), .flush(flush8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err8)
`endif
  );

  mux_pipe_reg #(.WIDTH(32), .NUM_INPUTS(5)) u_dut5 (
    .clk(clk), .reset(reset), .in_data(in_data5), .select(select5),
    .in_valid(in_valid5), .in_ready(in_ready5), .flush(flush5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef MUX_SEL_CHECK_EN
    , .sel_err(sel_err5)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the 8-input instance: words held in order, at most two.
  logic [31:0] mq [$];
  logic [31:0] exp_data;

  task automatic model_reset();
    mq.delete();
    exp_data = 32'h0;
  endtask

  // One clock edge; the model applies accept/deliver/flush from pre-edge inputs.
  task automatic cycle();
    bit acc, del, fl;
    logic [31:0] sv;
    acc = in_valid8 && (mq.size() < 2);
    del = out_ready8 && (mq.size() > 0);
    fl  = flush8;
    sv  = words8[select8];
    @(posedge clk);
    #1;
    if (del) $display("[%0t] deliver %h", $time, mq[0]);
    if (fl) begin
      mq.delete();
    end else begin
      if (del) void'(mq.pop_front());
      if (acc) mq.push_back(sv);
    end
    if (mq.size() > 0) exp_data = mq[0];
  endtask

  task automatic idle8();
    in_valid8 = 1'b0; flush8 = 1'b0; out_ready8 = 1'b0; select8 = '0;
    for (int k = 0; k < 8; k++) words8[k] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle8();
    in_valid5 = 1'b0; flush5 = 1'b0; out_ready5 = 1'b0; select5 = '0;
    for (int k = 0; k < 5; k++) words5[k] = $urandom | 32'h1;
    #12;
    n_cmp++; if (in_ready8 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready8); end
    n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid8); end
    n_cmp++; if (out_data8 !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %h expected 0", out_data8); end
    n_cmp++; if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1) begin n_bad++; $display("FAIL reset_dut5: got v=%b r=%b expected v=0 r=1", out_valid5, in_ready5); end
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    words8[3] = 32'hDEADBEEF;
    select8 = 3'd3; in_valid8 = 1'b1; out_ready8 = 1'b1;
    cycle();
    in_valid8 = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b1 || out_data8 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL basic_first: got v=%b d=%h expected v=1 d=deadbeef", out_valid8, out_data8); end
    cycle();
    n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL basic_one_cycle: got v=%b expected 0", out_valid8); end
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 8; k++) words8[k] = 32'h1000 + k;
    out_ready8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      select8 = 3'(i); in_valid8 = 1'b1;
      cycle();
      n_cmp++; if (out_valid8 !== 1'b1 || out_data8 !== 32'h1000 + i || in_ready8 !== 1'b1)
        begin n_bad++; $display("FAIL stream_%0d: got v=%b d=%h r=%b expected v=1 d=%h r=1", i, out_valid8, out_data8, in_ready8, 32'h1000 + i); end
    end
    in_valid8 = 1'b0;
    cycle();
    n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got v=%b expected 0", out_valid8); end
  endtask

  task automatic test_backpressure();
    logic [31:0] seq [3];
    seq[0] = 32'hA; seq[1] = 32'hB; seq[2] = 32'hC;
    words8[0] = seq[0]; words8[1] = seq[1]; words8[2] = seq[2];
    out_ready8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      select8 = 3'(i); in_valid8 = 1'b1;
      cycle();
    end
    n_cmp++; if (out_data8 !== 32'hA || out_valid8 !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=a", out_valid8, out_data8); end
    n_cmp++; if (in_ready8 !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b expected 0", in_ready8); end
    out_ready8 = 1'b1;
    for (int i = 1; i < 3; i++) begin
      cycle();
      n_cmp++; if (out_valid8 !== 1'b1 || out_data8 !== seq[i]) begin n_bad++; $display("FAIL bp_order_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid8, out_data8, seq[i]); end
    end
    in_valid8 = 1'b0;
    cycle();
    n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_bad++; $display("FAIL bp_empty: got v=%b r=%b expected v=0 r=1", out_valid8, in_ready8); end
  endtask

  task automatic test_flush();
    words8[0] = 32'h11; words8[1] = 32'h22; words8[2] = 32'h33;
    out_ready8 = 1'b0;
    select8 = 3'd0; in_valid8 = 1'b1; cycle();
    select8 = 3'd1; cycle();
    select8 = 3'd2; flush8 = 1'b1;
    cycle();
    flush8 = 1'b0; in_valid8 = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin n_bad++; $display("FAIL flush_clear: got v=%b r=%b expected v=0 r=1", out_valid8, in_ready8); end
    n_cmp++; if (out_data8 !== 32'h11) begin n_bad++; $display("FAIL flush_data_hold: got %h expected 11", out_data8); end
    out_ready8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL flush_no_emit_%0d: got v=%b d=%h expected v=0", i, out_valid8, out_data8); end
    end
  endtask

  task automatic test_out_of_range();
    idle8();
    out_ready5 = 1'b1; in_valid5 = 1'b1; select5 = 3'd2;
    cycle();
    n_cmp++; if (out_valid5 !== 1'b1 || out_data5 !== words5[2]) begin n_bad++; $display("FAIL oor_in_range: got v=%b d=%h expected v=1 d=%h", out_valid5, out_data5, words5[2]); end
`ifdef MUX_SEL_CHECK_EN
    n_cmp++; if (sel_err5 !== 1'b0) begin n_bad++; $display("FAIL oor_err_clean: got %b expected 0", sel_err5); end
`endif
    select5 = 3'd6;
    cycle();
    n_cmp++; if (out_valid5 !== 1'b1 || out_data5 !== 32'h0) begin n_bad++; $display("FAIL oor_zero: got v=%b d=%h expected v=1 d=0", out_valid5, out_data5); end
`ifdef MUX_SEL_CHECK_EN
    n_cmp++; if (sel_err5 !== 1'b1) begin n_bad++; $display("FAIL oor_err_set: got %b expected 1", sel_err5); end
`endif
    in_valid5 = 1'b0; flush5 = 1'b1;
    cycle();
    flush5 = 1'b0;
    n_cmp++; if (out_valid5 !== 1'b0) begin n_bad++; $display("FAIL oor_flush: got v=%b expected 0", out_valid5); end
`ifdef MUX_SEL_CHECK_EN
    n_cmp++; if (sel_err5 !== 1'b1) begin n_bad++; $display("FAIL oor_err_after_flush: got %b expected 1", sel_err5); end
`endif
    reset = 1'b1;
    #2;
`ifdef MUX_SEL_CHECK_EN
    n_cmp++; if (sel_err5 !== 1'b0) begin n_bad++; $display("FAIL oor_err_reset: got %b expected 0", sel_err5); end
`endif
    reset = 1'b0;
    model_reset();
    #1;
    out_ready5 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 8; k++) words8[k] = $urandom;
      select8    = 3'($urandom_range(0, 7));
      in_valid8  = ($urandom_range(0, 3) != 0);
      out_ready8 = ($urandom_range(0, 2) != 0);
      flush8     = ($urandom_range(0, 15) == 0);
      cycle();
      n_cmp++; if (out_valid8 !== (mq.size() > 0) || in_ready8 !== (mq.size() < 2) || out_data8 !== exp_data)
        begin n_bad++; $display("FAIL random_%0d: got v=%b r=%b d=%h expected v=%b r=%b d=%h", i, out_valid8, in_ready8, out_data8, mq.size() > 0, mq.size() < 2, exp_data); end
    end
    idle8();
    cycle();
  endtask

  task automatic test_async_reset();
    out_ready8 = 1'b0; in_valid8 = 1'b1;
    select8 = 3'd4; cycle();
    select8 = 3'd5; cycle();
    in_valid8 = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin n_bad++; $display("FAIL arst_pre: got v=%b r=%b expected v=1 r=0", out_valid8, in_ready8); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || out_data8 !== 32'h0)
      begin n_bad++; $display("FAIL arst_immediate: got v=%b r=%b d=%h expected v=0 r=1 d=0", out_valid8, in_ready8, out_data8); end
    #2;
    reset = 1'b0;
    model_reset();
    out_ready8 = 1'b1;
    cycle();
    n_cmp++; if (out_valid8 !== 1'b0) begin n_bad++; $display("FAIL arst_dropped: got v=%b d=%h expected v=0", out_valid8, out_data8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_streaming();
    test_backpressure();
    test_flush();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_pipe_reg.md
Name: mux_pipe_reg

Overview:
- Parametrised N:1 data selector with a registered valid/ready output stage and a one-entry skid buffer.
- Successor to the fixed 8-input 32-bit combinational selector.
- Used in the pipelined MIPS datapath wherever a selected operand must cross a stage boundary, such as forwarding-source selection into EX and writeback-source selection into WB.
- Supports stall (out_ready low) and flush without losing or duplicating data.

Parameters:
- WIDTH, 32: data width per input.
- NUM_INPUTS, 8: number of selectable inputs; must be at least 2; need not be a power of 2.
- SEL_W, $clog2(NUM_INPUTS): select width; derived localparam, not overridable.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_data, input, NUM_INPUTS*WIDTH: flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- select, input, SEL_W: input index, sampled with in_valid.
- in_valid, input, 1: upstream offers {in_data[select]}.
- in_ready, output, 1: block can accept; driven directly from a register.
- flush, input, 1: synchronous discard of all held entries.
- out_data, output, WIDTH: registered selected data.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts.
- sel_err, output, 1: present only with MUX_SEL_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - out_valid=0, out_data=0
  - skid_valid=0, skid_data=0
  - in_ready=1
- Reset asserted mid-transfer drops all held data immediately.
- Selection:
  - Computed combinationally as in_data[select*WIDTH +: WIDTH].
  - If select >= NUM_INPUTS, the selected value is all-zeros. This is a defined value, not X.
- Accept/deliver conditions:
  - Accept occurs when in_valid && in_ready.
  - Deliver occurs when out_valid && out_ready.
- Latency: an accepted word appears on out_data/out_valid on the next rising edge when the output register is empty or being drained. Throughput is 1 word/cycle.
- Storage is two entries, the output register (OUT) and the skid register (SKID), with in_ready = !skid_valid (registered).
- Per-edge update, flush=0:
  - OUT empty, or delivered this cycle:
    - If SKID is valid, OUT<=SKID and SKID is cleared.
    - Otherwise, if accepting, OUT<=the selected value.
    - Otherwise, out_valid<=0.
    - If SKID moved to OUT and an accept also occurs, the accepted word goes to OUT's place in order: OUT<=SKID, then SKID<=the new word. Strict FIFO order.
  - OUT full and not delivered:
    - An accept writes SKID and in_ready drops to 0 next cycle.
- Flush:
  - Flush=1 clears out_valid and skid_valid at the edge and sets in_ready<=1.
  - An accept in the same cycle is discarded; flush has priority.
  - A delivery in the same cycle counts as completed downstream; the block takes no further action on it.
  - Data registers hold their value; only the valid bits clear.
- out_data changes only when OUT is loaded. It stays stable while out_valid && !out_ready.
- No combinational path from out_ready to in_ready.

Optional Feature:
- Macro: MUX_SEL_CHECK_EN.
- Defined:
  - Adds the sel_err output (1 bit, reset 0).
  - sel_err is set sticky on any accept with select >= NUM_INPUTS.
  - It is cleared only by reset, not by flush.
  - The zero word is still passed through.
- Undefined:
  - No sel_err port.
  - Out-of-range select silently yields zero.
  - Logic otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W=32
  - FWD_SRC_* select constants: 0 regfile, 1 EX/MEM, 2 MEM/WB
  - WB_SRC_* select constants
- One natural sub-module: skid_reg, a generic WIDTH-wide 2-entry valid/ready register. mux_pipe_reg instantiates it behind a combinational selector.

Test Plan:
- Reset/basic: after reset expect in_ready=1, out_valid=0, out_data=0. Drive in_data input3=0xDEADBEEF, select=3, in_valid=1 for one cycle with out_ready=1. Expect out_data=0xDEADBEEF and out_valid=1 on the next edge only.
- Streaming: select 0..7 on consecutive cycles, input k=0x1000+k, out_ready=1. Expect 0x1000..0x1007 in order at one per cycle, in_ready constantly 1.
- Backpressure: hold out_ready=0 and offer 0xA, 0xB, 0xC.
  - Expect out_data=0xA held, 0xB in SKID, in_ready=0; 0xC not accepted.
  - Then raise out_ready. Expect 0xA, 0xB, 0xC delivered in order with no loss or duplication.
- Flush: with OUT=0x11 and SKID=0x22 held, assert flush together with in_valid carrying 0x33. Expect next cycle out_valid=0, in_ready=1, and 0x33 never emitted.
- Out-of-range: set NUM_INPUTS=5, select=6, in_valid=1. Expect out_data=0. With MUX_SEL_CHECK_EN expect sel_err=1 after the edge, still 1 after a flush, and 0 after reset.
- Async reset mid-stall: assert reset between clock edges while out_valid=1 and in_ready=0. Expect out_valid=0 and in_ready=1 immediately, before the next edge.
